// File: rtl/viterbi_pkg.sv
// viterbi_pkg -- shared definitions for the K=3 rate-1/2 convolutional code
// used by encoder2 and the Viterbi decoder.
//
// Contents: state count, generator polynomials, path-metric width/type,
// branch-output, Hamming-distance and saturating-add helpers.
//
// Build option: DECODER_PM_NORM_EN selects 8-bit metrics (normalized each
// step by the decoder); otherwise metrics are 16-bit and saturate.
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam logic [2:0] G1 = 3'b111;
   localparam logic [2:0] G0 = 3'b101;

`ifdef DECODER_PM_NORM_EN
   localparam int PM_W = 8;
`else
   localparam int PM_W = 16;
`endif

   typedef logic [PM_W-1:0] metric_t;

   localparam metric_t PM_ZERO = metric_t'(5'd0);
   localparam metric_t PM_INIT = metric_t'(5'd16);
   localparam metric_t PM_SAT  = '1;

   // Code bits for input bit_in leaving state {b[k-1], b[k-2]}.
   // The register is {b, s[1], s[0]}; G1 taps all three, G0 taps b and s[0].
   function automatic logic [1:0] branch_out(input logic [1:0] state, input logic bit_in);
      logic [2:0] reg_v;
      reg_v = {bit_in, state};
      return {^(reg_v & G1), ^(reg_v & G0)};
   endfunction

   // Hamming distance between two 2-bit symbols, 0..2.
   function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] x_v;
      x_v = a ^ b;
      return {1'b0, x_v[1]} + {1'b0, x_v[0]};
   endfunction

   // Metric + branch metric, clamped at all-ones so a metric can never wrap.
   function automatic metric_t sat_add(input metric_t pm, input logic [1:0] bm);
      logic [PM_W:0] sum_v;
      sum_v = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
      if (sum_v[PM_W]) begin
         return PM_SAT;
      end else begin
         return sum_v[PM_W-1:0];
      end
   endfunction

endpackage

// File: rtl/encoder2.sv
// encoder2 -- K=3 rate-1/2 convolutional encoder (G1=111, G0=101).
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (state and output to 0)
//   enable : d_in is a valid data bit this cycle
//   d_in   : data bit
//   d_out  : registered code symbol, bit1 = G1 output, bit0 = G0 output
module encoder2
   import viterbi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       d_in,
   output logic [1:0] d_out
);

   logic [1:0] state_r;
   logic [1:0] d_out_r;

   // Shift register and registered code symbol.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= 2'b00;
         d_out_r <= 2'b00;
      end else if (enable) begin
         d_out_r <= branch_out(state_r, d_in);
         state_r <= {d_in, state_r[1]};
      end else begin
         state_r <= state_r;
         d_out_r <= d_out_r;
      end
   end

   assign d_out = d_out_r;

endmodule

// File: rtl/viterbi_acs.sv
// viterbi_acs -- add-compare-select and register-exchange survivor for one
// trellis state of the K=3 Viterbi decoder.
//
// A state ns = {n1, n0} is reached from predecessors {n0,0} and {n0,1} with
// input bit n1. The caller wires those predecessors' metrics/survivors in.
//
// Ports:
//   clk, rst, enable : clock, sync active-high reset, step enable
//   d_in             : received 2-bit hard-decision symbol
//   pm_p0 / pm_p1    : metric of predecessor {n0,0} / {n0,1}
//   surv_p0 / surv_p1: survivor of predecessor {n0,0} / {n0,1}
//   norm_sub         : (DECODER_PM_NORM_EN only) value subtracted this step
//   pm_new_s         : (DECODER_PM_NORM_EN only) un-normalized new metric
//   pm_r             : this state's registered path metric
//   surv_r           : this state's registered survivor (LSB = newest bit)
module viterbi_acs
   import viterbi_pkg::*;
#(
   parameter int         TB_DEPTH = 16,
   parameter logic [1:0] STATE    = 2'd0
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [1:0]          d_in,
   input  metric_t             pm_p0,
   input  metric_t             pm_p1,
   input  logic [TB_DEPTH-1:0] surv_p0,
   input  logic [TB_DEPTH-1:0] surv_p1,
`ifdef DECODER_PM_NORM_EN
   input  metric_t             norm_sub,
   output metric_t             pm_new_s,
`endif
   output metric_t             pm_r,
   output logic [TB_DEPTH-1:0] surv_r
);

   localparam logic [1:0] PRED0  = {STATE[0], 1'b0};
   localparam logic [1:0] PRED1  = {STATE[0], 1'b1};
   localparam logic       IN_BIT = STATE[1];
   localparam metric_t    RST_PM = (STATE == 2'd0) ? PM_ZERO : PM_INIT;

   logic [1:0]          bm0_s;
   logic [1:0]          bm1_s;
   metric_t             sum0_s;
   metric_t             sum1_s;
   metric_t             pm_win_s;
   metric_t             pm_next_s;
   logic [TB_DEPTH-1:0] surv_win_s;

   // Add-compare-select; strict less-than lets the lower predecessor win ties.
   always_comb begin
      bm0_s  = hamming2(d_in, branch_out(PRED0, IN_BIT));
      bm1_s  = hamming2(d_in, branch_out(PRED1, IN_BIT));
      sum0_s = sat_add(pm_p0, bm0_s);
      sum1_s = sat_add(pm_p1, bm1_s);
      if (sum1_s < sum0_s) begin
         pm_win_s   = sum1_s;
         surv_win_s = surv_p1;
      end else begin
         pm_win_s   = sum0_s;
         surv_win_s = surv_p0;
      end
   end

`ifdef DECODER_PM_NORM_EN
   assign pm_new_s  = pm_win_s;
   assign pm_next_s = pm_win_s - norm_sub;
`else
   assign pm_next_s = pm_win_s;
`endif

   // Metric and survivor registers; survivor shifts in this state's input bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         pm_r   <= RST_PM;
         surv_r <= '0;
      end else if (enable) begin
         pm_r   <= pm_next_s;
         surv_r <= {surv_win_s[TB_DEPTH-2:0], IN_BIT};
      end else begin
         pm_r   <= pm_r;
         surv_r <= surv_r;
      end
   end

endmodule

// File: rtl/decoder.sv
// decoder -- hard-decision Viterbi decoder for the K=3 rate-1/2 code
// produced by encoder2, register-exchange survivors of TB_DEPTH bits.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   enable : d_in carries a valid code symbol this cycle
//   d_in   : received symbol, bit1 = G1 output, bit0 = G0 output
//   d_out  : registered decoded bit; the bit for symbol k appears after the
//            enabled edge that consumes symbol k+TB_DEPTH
//
// Build option: DECODER_PM_NORM_EN -- 8-bit metrics with the minimum new
// metric subtracted from all states each step. Without it, 16-bit metrics
// saturate at all-ones.
module decoder
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] d_in,
   output logic       d_out
);

   metric_t             pm_r   [NUM_STATES];
   logic [TB_DEPTH-1:0] surv_r [NUM_STATES];
   logic [1:0]          best_s;
   metric_t             best_pm_s;
   logic                dec_bit_s;
   logic                d_out_r;

`ifdef DECODER_PM_NORM_EN
   metric_t             pm_new_s [NUM_STATES];
   metric_t             norm_sub_s;

   // Smallest new metric, removed from every state so metrics stay small.
   always_comb begin
      norm_sub_s = pm_new_s[0];
      for (int i = 1; i < NUM_STATES; i++) begin
         if (pm_new_s[i] < norm_sub_s) begin
            norm_sub_s = pm_new_s[i];
         end else begin
            norm_sub_s = norm_sub_s;
         end
      end
   end
`endif

   for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_acs
      // Predecessors of {n1,n0} are {n0,0} and {n0,1}.
      localparam int P0 = (gi % 2) * 2;
      localparam int P1 = P0 + 1;

      viterbi_acs #(
         .TB_DEPTH (TB_DEPTH),
         .STATE    (2'(gi))
      ) u_acs (
         .clk      (clk),
         .rst      (rst),
         .enable   (enable),
         .d_in     (d_in),
         .pm_p0    (pm_r[P0]),
         .pm_p1    (pm_r[P1]),
         .surv_p0  (surv_r[P0]),
         .surv_p1  (surv_r[P1]),
`ifdef DECODER_PM_NORM_EN
         .norm_sub (norm_sub_s),
         .pm_new_s (pm_new_s[gi]),
`endif
         .pm_r     (pm_r[gi]),
         .surv_r   (surv_r[gi])
      );
   end

   // Best state from the metrics before this step's update; lowest index on tie.
   always_comb begin
      best_s    = 2'd0;
      best_pm_s = pm_r[0];
      for (int i = 1; i < NUM_STATES; i++) begin
         if (pm_r[i] < best_pm_s) begin
            best_s    = 2'(i);
            best_pm_s = pm_r[i];
         end else begin
            best_s    = best_s;
            best_pm_s = best_pm_s;
         end
      end
      dec_bit_s = surv_r[best_s][TB_DEPTH-1];
   end

   // Decoded output register, holds while enable is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_out_r <= 1'b0;
      end else if (enable) begin
         d_out_r <= dec_bit_s;
      end else begin
         d_out_r <= d_out_r;
      end
   end

   assign d_out = d_out_r;

endmodule

// File: tb/tb_decoder.sv
// tb_decoder -- directed self-checking bench for decoder (and encoder2).
// The bench encodes data with its own K=3 model, feeds symbols (optionally
// corrupted) to the decoder, and expects d_out to be the data delayed by D.
module tb_decoder;

   localparam int D = 16;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [1:0] d_in;
   logic       d_out;
   logic       enc_in;
   logic [1:0] enc_out;

   int         checks;
   int         errors;
   string      phase;

   logic [1:0] enc_s;
   logic       hist [$];
   logic       last_exp;
   logic [1:0] last_sym;
   logic [15:0] lfsr;

   decoder #(.TB_DEPTH(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .d_in   (d_in),
      .d_out  (d_out)
   );

   encoder2 u_enc (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .d_in   (enc_in),
      .d_out  (enc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic next_bit(output logic b);
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      b = lfsr[0];
   endtask

   // One enabled symbol: encode b with the model, corrupt by err, check outputs.
   task automatic step(input logic b, input logic [1:0] err);
      logic [1:0] sym;
      int         k;
      logic       exp;
      sym    = {b ^ enc_s[1] ^ enc_s[0], b ^ enc_s[0]};
      enable = 1'b1;
      d_in   = sym ^ err;
      enc_in = b;
      @(posedge clk);
      #1;
      enc_s = {b, enc_s[1]};
      hist.push_back(b);
      k   = hist.size() - 1;
      exp = (k >= D) ? hist[k-D] : 1'b0;
      last_exp = exp;
      last_sym = sym;
      chk("d_out", {31'd0, d_out}, {31'd0, exp});
      chk("enc_out", {30'd0, enc_out}, {30'd0, sym});
   endtask

   task automatic do_reset(input logic en);
      rst    = 1'b1;
      enable = en;
      d_in   = 2'b11;
      enc_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      enable = 1'b0;
      chk("rst_d_out", {31'd0, d_out}, 32'd0);
      chk("rst_pm0", 32'(dut.pm_r[0]), 32'd0);
      chk("rst_pm1", 32'(dut.pm_r[1]), 32'd16);
      chk("rst_pm2", 32'(dut.pm_r[2]), 32'd16);
      chk("rst_pm3", 32'(dut.pm_r[3]), 32'd16);
      chk("rst_surv0", 32'(dut.surv_r[0]), 32'd0);
      chk("rst_surv3", 32'(dut.surv_r[3]), 32'd0);
      chk("rst_enc", {30'd0, enc_out}, 32'd0);
      enc_s    = 2'b00;
      last_exp = 1'b0;
      last_sym = 2'b00;
      hist.delete();
   endtask

   initial begin
      logic b;
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      enable = 1'b0;
      d_in   = 2'b00;
      enc_in = 1'b0;
      enc_s  = 2'b00;

      phase = "reset";
      do_reset(1'b0);

      phase = "clean";
      lfsr = 16'hACE1;
      for (int i = 0; i < 256; i++) begin
         next_bit(b);
         step(b, 2'b00);
      end

      phase = "reset_mid";
      do_reset(1'b1);

      phase = "zeros";
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 2'b00);
      end

      phase = "single_err";
      do_reset(1'b0);
      lfsr = 16'hACE1;
      for (int i = 0; i < 256; i++) begin
         next_bit(b);
         step(b, (i % 20 == 10) ? 2'b10 : 2'b00);
      end

      phase = "burst_err";
      do_reset(1'b0);
      lfsr = 16'hACE1;
      for (int i = 0; i < 256; i++) begin
         next_bit(b);
         step(b, ((i % 20 == 10) || (i % 20 == 11)) ? 2'b10 : 2'b00);
      end

      phase = "hold";
      do_reset(1'b0);
      lfsr = 16'h1D2B;
      for (int i = 0; i < 40; i++) begin
         next_bit(b);
         step(b, 2'b00);
      end
      enable = 1'b0;
      d_in   = 2'b11;
      enc_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_d_out", {31'd0, d_out}, {31'd0, last_exp});
         chk("hold_enc", {30'd0, enc_out}, {30'd0, last_sym});
      end
      for (int i = 0; i < 60; i++) begin
         next_bit(b);
         step(b, 2'b00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
